ifu_fetch_unit: RTL and testbench

- Instruction fetch unit: owns the architectural fetch PC and drives `current_pc` and `fetch_addr_misaligned` into the core.
- Issues word fetches on a req/gnt/rvalid instruction-memory port and buffers returned instructions in a 2-entry queue for decode.
- Accepts branch/jump redirects from execute and trap redirects from the trap unit.
- Raises `fetch_addr_misaligned` whenever the PC is not 4-byte aligned, and then stops fetching until a trap redirect.

---
 rtl/ifu_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_ifu_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: fetch PC, req/gnt/rvalid memory port, 2-entry instruction queue.
// Optional IFU_PERF_EN adds a 32-bit fetch_count of instructions consumed by decode.
module ifu_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            cpu_rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
`ifdef IFU_PERF_EN
  output logic [31:0]     fetch_count,
`endif
  output logic [XLEN-1:0] current_pc,
  output logic            fetch_addr_misaligned
);

  typedef enum logic {StRun, StFault} state_e;

  state_e          state_q;
  logic [XLEN-1:0] current_pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            outstanding_q;
  logic            discard_q;
  logic [31:0]     data_q [2];
  logic [XLEN-1:0] pc_q   [2];
  logic            rd_ptr_q;
  logic            wr_ptr_q;
  logic [1:0]      count_q;

  logic            misaligned;
  logic            take_redirect;
  logic [XLEN-1:0] target;
  logic            grant;
  logic            push;
  logic            pop;

  always_comb begin
    misaligned    = current_pc_q[1:0] != 2'b00;
    // In FAULT only a trap can move the PC.
    take_redirect = trap_valid || (redirect_valid && (state_q == StRun));
    target        = trap_valid ? trap_pc : redirect_pc;
    // Reset gates the request so the port is quiet while cpu_rstn is held low.
    imem_req      = cpu_rstn && (state_q == StRun) && !misaligned && !outstanding_q &&
                    (count_q != 2'd2) && !redirect_valid && !trap_valid;
    grant         = imem_req && imem_gnt;
    // Responses are only accepted for a request we actually own.
    push          = imem_rvalid && outstanding_q && !discard_q && !take_redirect;
    pop           = instr_valid && instr_ready && !take_redirect;
  end

  assign imem_addr             = current_pc_q;
  assign current_pc            = current_pc_q;
  assign fetch_addr_misaligned = misaligned;
  assign instr_valid           = count_q != 2'd0;
  assign instr_data            = data_q[rd_ptr_q];
  assign instr_pc              = pc_q[rd_ptr_q];

  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q       <= StRun;
      current_pc_q  <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      if (trap_valid) begin
        state_q <= StRun;
      end else if ((state_q == StRun) && !take_redirect && misaligned) begin
        state_q <= StFault;
      end

      if (take_redirect) begin
        current_pc_q <= target;
      end else if (grant) begin
        current_pc_q <= current_pc_q + XLEN'(4);
      end

      if (grant) begin
        outstanding_q <= 1'b1;
        req_pc_q      <= current_pc_q;
      end else if (imem_rvalid) begin
        outstanding_q <= 1'b0;
      end

      // A redirect with a response still in flight must drop that response later.
      if (imem_rvalid) begin
        discard_q <= 1'b0;
      end else if (take_redirect && outstanding_q) begin
        discard_q <= 1'b1;
      end

      if (take_redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= imem_rdata;
          pc_q[wr_ptr_q]   <= req_pc_q;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        unique case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      fetch_count_q <= '0;
    end else if (instr_valid && instr_ready) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed, table-driven bench for ifu_fetch_unit; each vector drives one cycle of inputs
// and checks the outputs that should be visible before the following clock edge.
module tb_ifu_fetch_unit;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_mis;
    logic        e_ivalid;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
  } vec_t;

  logic        clk = 1'b0;
  logic        cpu_rstn;
  logic        redirect_valid, trap_valid;
  logic [31:0] redirect_pc, trap_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc, current_pc;
  logic        fetch_addr_misaligned;
`ifdef IFU_PERF_EN
  logic [31:0] fetch_count;
`endif

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;
  int exp_pops = 0;

  ifu_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk                   (clk),
    .cpu_rstn              (cpu_rstn),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .trap_valid            (trap_valid),
    .trap_pc               (trap_pc),
    .imem_req              (imem_req),
    .imem_addr             (imem_addr),
    .imem_gnt              (imem_gnt),
    .imem_rvalid           (imem_rvalid),
    .imem_rdata            (imem_rdata),
    .instr_valid           (instr_valid),
    .instr_data            (instr_data),
    .instr_pc              (instr_pc),
    .instr_ready           (instr_ready),
`ifdef IFU_PERF_EN
    .fetch_count           (fetch_count),
`endif
    .current_pc            (current_pc),
    .fetch_addr_misaligned (fetch_addr_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
    end
  endtask

  task automatic drive_idle();
    redirect_valid = 1'b0; redirect_pc = '0; trap_valid = 1'b0; trap_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_pc", current_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", {31'b0, fetch_addr_misaligned}, 32'h0);
    chk("rst_ivalid", {31'b0, instr_valid}, 32'h0);
    chk("rst_idata", instr_data, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
`ifdef IFU_PERF_EN
    chk("rst_fetch_count", fetch_count, 32'h0);
`endif
  endtask

  // Drive one cycle, check pre-edge outputs, then advance past the edge.
  task automatic step(input vec_t v);
    redirect_valid = v.rv;  redirect_pc = v.rpc;
    trap_valid     = v.tv;  trap_pc     = v.tpc;
    imem_gnt       = v.gnt; imem_rvalid = v.rvalid; imem_rdata = v.rdata;
    instr_ready    = v.ready;
    #2;
    chk("req", {31'b0, imem_req}, {31'b0, v.e_req});
    chk("current_pc", current_pc, v.e_pc);
    chk("imem_addr", imem_addr, v.e_pc);
    chk("misaligned", {31'b0, fetch_addr_misaligned}, {31'b0, v.e_mis});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, v.e_ivalid});
    if (v.e_ivalid) begin
      chk("instr_pc", instr_pc, v.e_ipc);
      chk("instr_data", instr_data, v.e_idata);
    end
`ifdef IFU_PERF_EN
    chk("fetch_count", fetch_count, exp_pops);
`endif
    if (v.ready && v.e_ivalid) exp_pops++;
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[15];
    // rv rpc tv tpc | gnt rvalid rdata ready | req pc mis | ivalid ipc idata
    tbl[0]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0013, 1'b0,
                1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h4, 1'b0, 1'b1, 32'h0, 32'h1111_0013};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0013, 1'b1,
                1'b0, 32'h8, 1'b0, 1'b1, 32'h0, 32'h1111_0013};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                1'b1, 32'h8, 1'b0, 1'b1, 32'h4, 32'h2222_0013};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_0013, 1'b1,
                1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                1'b1, 32'hC, 1'b0, 1'b1, 32'h8, 32'h3333_0013};
    tbl[7]  = '{1'b1, 32'h102, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h102, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h102, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h102, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h102, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[13] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0013, 1'b0,
                1'b0, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[14] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                1'b1, 32'h84, 1'b0, 1'b1, 32'h80, 32'h4444_0013};

    drive_idle();
    cpu_rstn = 1'b1;
    #1 cpu_rstn = 1'b0;
    #2 check_reset_state();
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_rstn = 1'b1;

    // Sequential fetch from reset, misaligned redirect, fault, trap recovery.
    foreach (tbl[i]) step(tbl[i]);

    // Redirect to 0x40 while 0x10 is outstanding: stale response dropped.
    step(vec_t'{1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0010, 1'b0,
                1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_0013, 1'b0,
                1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h44, 1'b0, 1'b1, 32'h40, 32'h5555_0013});
    // Redirect and trap together: trap wins, buffer flushed.
    step(vec_t'{1'b1, 32'h300, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h44, 1'b0, 1'b1, 32'h40, 32'h5555_0013});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0});
    // Redirect in the rvalid cycle drops that response without setting discard.
    step(vec_t'{1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0080, 1'b0,
                1'b0, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0});

    // Full buffer back-pressure and PC wrap at the top of the address space.
    step(vec_t'{1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0A0_0013, 1'b0,
                1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hA0A0_0013});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA1A1_0013, 1'b0,
                1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hA0A0_0013});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hA0A0_0013});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hA0A0_0013});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA1A1_0013});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});

    // Trap to a misaligned vector: flag stays high, redirect ignored in FAULT.
    step(vec_t'{1'b0, 32'h0, 1'b1, 32'h81, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h81, 1'b1, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h81, 1'b1, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h81, 1'b1, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB0B0_0013, 1'b0,
                1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h4, 1'b0, 1'b1, 32'h0, 32'hB0B0_0013});

    // Asynchronous reset mid-burst with a grant outstanding and one entry buffered.
    drive_idle();
    cpu_rstn = 1'b0;
    exp_pops = 0;
    #1 check_reset_state();
    @(posedge clk); #1;
    cpu_rstn = 1'b1;
    // A late response for the pre-reset grant must be ignored.
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0008, 1'b0,
                1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});
    step(vec_t'{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
